// File: rtl/soc_test_monitor.sv
// End-of-test monitor: snoops each core's data-memory write port for a finished
// flag and a result word, applies a cycle timeout and reports done/pass/timeout.
module soc_test_monitor #(
  parameter int                    NUM_CORES      = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR      = 32'h0000_0FF0,
  parameter logic [ADDR_WIDTH-1:0] RESULT_ADDR    = 32'h0000_0FF4,
  parameter int                    TIMEOUT_CYCLES = 1000,
  parameter int                    CNT_WIDTH      = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [DATA_WIDTH-1:0]           expected_i,
  input  logic [NUM_CORES-1:0]            req_i,
  input  logic [NUM_CORES-1:0]            we_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] wdata_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            pass_o,
  output logic                            timeout_o,
  output logic [NUM_CORES-1:0]            flag_o,
  output logic [NUM_CORES-1:0]            mismatch_o,
  output logic [NUM_CORES*DATA_WIDTH-1:0] result_o,
  output logic [CNT_WIDTH-1:0]            cycles_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t                          state_q;
  logic [DATA_WIDTH-1:0]           expected_q;
  logic [NUM_CORES-1:0]            flag_set;
  logic [NUM_CORES-1:0]            flag_next;
  logic [NUM_CORES-1:0]            mismatch_next;
  logic [NUM_CORES*DATA_WIDTH-1:0] result_next;
  logic                            all_flags;
  logic                            timeout_hit;
  logic [CNT_WIDTH-1:0]            cycles_inc;

  // Results freeze per core once that core's flag is set; the final-cycle
  // captures feed the mismatch vector so status matches the visible results.
  always_comb begin
    flag_set      = '0;
    result_next   = result_o;
    mismatch_next = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (req_i[k] && we_i[k] && addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == FLAG_ADDR &&
          wdata_i[k*DATA_WIDTH +: DATA_WIDTH] != '0)
        flag_set[k] = 1'b1;
      if (req_i[k] && we_i[k] && addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == RESULT_ADDR &&
          !flag_o[k])
        result_next[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      mismatch_next[k] = (result_next[k*DATA_WIDTH +: DATA_WIDTH] != expected_q);
    end
    flag_next   = flag_o | flag_set;
    all_flags   = &flag_next;
    timeout_hit = (cycles_o == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    cycles_inc  = (&cycles_o) ? cycles_o : cycles_o + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      expected_q <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      timeout_o  <= 1'b0;
      flag_o     <= '0;
      mismatch_o <= '0;
      result_o   <= '0;
      cycles_o   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start_i) begin
            state_q    <= S_RUN;
            expected_q <= expected_i;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            timeout_o  <= 1'b0;
            flag_o     <= '0;
            mismatch_o <= '0;
            result_o   <= '0;
            cycles_o   <= '0;
          end
        end
        S_RUN: begin
          flag_o   <= flag_next;
          result_o <= result_next;
          // A completing flag beats a timeout landing on the same cycle.
          if (all_flags) begin
            state_q    <= S_DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            pass_o     <= ~|mismatch_next;
            mismatch_o <= mismatch_next;
            cycles_o   <= cycles_inc;
          end else if (timeout_hit) begin
            state_q    <= S_TIMEOUT;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b1;
            mismatch_o <= mismatch_next;
          end else begin
            cycles_o <= cycles_inc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_test_monitor.sv
// Bench for soc_test_monitor: per-cycle write schedules (directed and random)
// are driven into the monitor and compared with an event-level outcome model.
module tb_soc_test_monitor;

  localparam int NC   = 2;
  localparam int T    = 100;
  localparam int MAXC = 128;
  localparam logic [31:0] FLAG = 32'h0000_0FF0;
  localparam logic [31:0] RES  = 32'h0000_0FF4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           start_i = 1'b0;
  logic [31:0]    expected_i = '0;
  logic [NC-1:0]  req_i = '0;
  logic [NC-1:0]  we_i = '0;
  logic [NC*32-1:0] addr_i = '0;
  logic [NC*32-1:0] wdata_i = '0;
  logic           busy_o, done_o, pass_o, timeout_o;
  logic [NC-1:0]  flag_o, mismatch_o;
  logic [NC*32-1:0] result_o;
  logic [31:0]    cycles_o;

  soc_test_monitor #(
    .NUM_CORES(NC), .ADDR_WIDTH(32), .DATA_WIDTH(32), .FLAG_ADDR(FLAG),
    .RESULT_ADDR(RES), .TIMEOUT_CYCLES(T), .CNT_WIDTH(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .expected_i(expected_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .flag_o(flag_o), .mismatch_o(mismatch_o), .result_o(result_o), .cycles_o(cycles_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Per-cycle stimulus schedule
  logic        req_a  [MAXC][NC];
  logic        we_a   [MAXC][NC];
  logic [31:0] addr_a [MAXC][NC];
  logic [31:0] data_a [MAXC][NC];
  int          start_at;

  // Model outcome
  logic        m_done, m_timeout;
  logic [NC-1:0] m_flag;
  logic [31:0] m_res [NC];
  logic [31:0] m_cycles;

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++)
      for (int k = 0; k < NC; k++) begin
        req_a[c][k] = 1'b0; we_a[c][k] = 1'b0; addr_a[c][k] = '0; data_a[c][k] = '0;
      end
    start_at = -1;
  endtask

  task automatic put(input int c, input int k, input logic rq, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    req_a[c][k] = rq; we_a[c][k] = w; addr_a[c][k] = a; data_a[c][k] = d;
  endtask

  // Outcome from the rules: each core finishes at its first non-zero flag write;
  // the run ends at the latest finish, or at cycle T-1 if some core never finishes.
  task automatic model();
    int fc [NC];
    int last;
    bool_all: begin end
    for (int k = 0; k < NC; k++) begin
      fc[k] = -1;
      for (int c = T - 1; c >= 0; c--)
        if (req_a[c][k] && we_a[c][k] && addr_a[c][k] == FLAG && data_a[c][k] != 0)
          fc[k] = c;
    end
    m_done = 1'b1;
    last = 0;
    for (int k = 0; k < NC; k++) begin
      if (fc[k] < 0) m_done = 1'b0;
      else if (fc[k] > last) last = fc[k];
    end
    if (m_done) begin
      m_timeout = 1'b0; m_cycles = 32'(last + 1);
    end else begin
      m_timeout = 1'b1; last = T - 1; m_cycles = 32'(T - 1);
    end
    for (int k = 0; k < NC; k++) begin
      m_flag[k] = (fc[k] >= 0);
      m_res[k] = '0;
      for (int c = 0; c <= last; c++)
        if (req_a[c][k] && we_a[c][k] && addr_a[c][k] == RES && (fc[k] < 0 || c < fc[k]))
          m_res[k] = data_a[c][k];
    end
  endtask

  task automatic drive_idle();
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; start_i = 1'b0;
  endtask

  task automatic run_sched(input string name, input logic [31:0] e, input int rst_at);
    bit ended;
    logic [NC-1:0] m_mis;
    logic [NC*32-1:0] m_res_packed;
    model();
    @(negedge clk_i);
    start_i = 1'b1; expected_i = e;
    ended = 1'b0;
    for (int c = 0; c <= T + 3; c++) begin
      @(negedge clk_i);
      if (!busy_o) begin ended = 1'b1; break; end
      chk({name, ".cycles_run"}, 64'(cycles_o), 64'(c));
      if (c == 0) chk({name, ".flags_clr"}, 64'(flag_o), 64'(0));
      start_i = (c == start_at);
      for (int k = 0; k < NC; k++) begin
        req_i[k] = req_a[c][k]; we_i[k] = we_a[c][k];
        addr_i[k*32 +: 32] = addr_a[c][k]; wdata_i[k*32 +: 32] = data_a[c][k];
      end
      if (c == rst_at) begin
        #2 rst_i = 1'b1;
        #1;
        chk({name, ".rst_status"}, 64'({busy_o, done_o, pass_o, timeout_o, flag_o, mismatch_o}), 64'(0));
        chk({name, ".rst_result"}, 64'(result_o), 64'(0));
        chk({name, ".rst_cycles"}, 64'(cycles_o), 64'(0));
        drive_idle();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        return;
      end
    end
    drive_idle();
    if (!ended) chk({name, ".end_bound"}, 64'(0), 64'(1));
    m_mis = '0;
    for (int k = 0; k < NC; k++) begin
      m_mis[k] = (m_res[k] != e);
      m_res_packed[k*32 +: 32] = m_res[k];
    end
    chk({name, ".done"}, 64'(done_o), 64'(m_done));
    chk({name, ".timeout"}, 64'(timeout_o), 64'(m_timeout));
    chk({name, ".pass"}, 64'(pass_o), 64'(m_done && m_mis == '0));
    chk({name, ".busy"}, 64'(busy_o), 64'(0));
    chk({name, ".flag"}, 64'(flag_o), 64'(m_flag));
    chk({name, ".mismatch"}, 64'(mismatch_o), 64'(m_mis));
    chk({name, ".result"}, 64'(result_o), 64'(m_res_packed));
    chk({name, ".cycles"}, 64'(cycles_o), 64'(m_cycles));
    repeat (2) @(negedge clk_i);
    chk({name, ".hold"}, 64'({done_o, timeout_o, busy_o}), 64'({m_done, m_timeout, 1'b0}));
  endtask

  task automatic sched_basic(input logic [31:0] r1);
    clear_sched();
    put(5, 0, 1, 1, RES, 32'd55);
    put(10, 0, 1, 1, FLAG, 32'd1);
    put(15, 1, 1, 1, RES, r1);
    put(20, 1, 1, 1, FLAG, 32'd1);
  endtask

  task automatic sched_random(input logic [31:0] e);
    int fc, sel;
    clear_sched();
    for (int k = 0; k < NC; k++) begin
      fc = $urandom_range(0, 115);
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          sel = $urandom_range(0, 4);
          case (sel)
            0: put(c, k, 1, 1, RES, ($urandom_range(0, 3) == 0) ? e + 1 : e);
            1: put(c, k, 1, 1, FLAG, 32'd0);
            2: put(c, k, 1, 0, FLAG, $urandom | 32'd1);
            3: put(c, k, 1, 1, RES + 4, $urandom | 32'd1);
            default: put(c, k, 0, 1, FLAG, $urandom | 32'd1);
          endcase
        end
      end
      put(fc, k, 1, 1, FLAG, $urandom | 32'd1);
    end
    if ($urandom_range(0, 1) == 1) start_at = $urandom_range(1, 30);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("reset.status", 64'({busy_o, done_o, pass_o, timeout_o, flag_o, mismatch_o}), 64'(0));
    chk("reset.result", 64'(result_o), 64'(0));
    chk("reset.cycles", 64'(cycles_o), 64'(0));
    rst_i = 1'b0;

    sched_basic(32'd55);
    run_sched("pass_run", 32'd55, -1);
    chk("pass_run.cycles21", 64'(cycles_o), 64'(21));

    sched_basic(32'd54);
    run_sched("mis_run", 32'd55, -1);
    chk("mis_run.vec", 64'(mismatch_o), 64'(2'b10));

    clear_sched();
    put(10, 0, 1, 1, FLAG, 32'd1);
    run_sched("timeout_run", 32'd55, -1);
    chk("timeout_run.cycles99", 64'(cycles_o), 64'(99));

    clear_sched();
    put(T - 1, 0, 1, 1, FLAG, 32'd7);
    put(T - 1, 1, 1, 1, FLAG, 32'd9);
    run_sched("tie_run", 32'd0, -1);

    clear_sched();
    put(2, 0, 1, 1, RES, 32'd55);
    put(3, 0, 1, 1, FLAG, 32'd0);
    put(4, 1, 1, 0, FLAG + 4, 32'd99);
    put(6, 1, 1, 1, RES, 32'd55);
    put(10, 0, 1, 1, FLAG, 32'd1);
    put(12, 0, 1, 1, RES, 32'd77);
    put(20, 1, 1, 1, FLAG, 32'd1);
    start_at = 8;
    run_sched("edge_run", 32'd55, -1);

    sched_basic(32'd55);
    run_sched("reset_run", 32'd55, 12);
    sched_basic(32'd55);
    run_sched("after_reset", 32'd55, -1);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] e;
      e = $urandom;
      sched_random(e);
      run_sched($sformatf("rand%0d", i), e, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
